// File: rtl/riscv_defines.sv
// Shared core definitions used by the fetch stage: word width, fetch buffer
// depth, fetch FSM states and the buffered fetch entry layout.
package riscv_defines;

  localparam int unsigned WORD_WIDTH       = 32;
  localparam int unsigned FETCH_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_REQ,
    IF_WAIT
  } if_state_e;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] instr;
    logic [WORD_WIDTH-1:0] pc;
  } fetch_entry_t;

  function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] addr);
    return {addr[WORD_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding {instruction, pc}; flush dominates
// push and pop, and the head reads as zero while empty.
module fetch_fifo
  import riscv_defines::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
    head    = (count != 2'd0) ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word
// requests, buffers responses and handles execute-stage redirects.
module if_stage
  import riscv_defines::*;
#(
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned           FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_enable_i,
  input  logic                  pc_branch_ctrl_i,
  input  logic [WORD_WIDTH-1:0] pc_branch_addr_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  output logic                  instr_valid_o,
  output logic [WORD_WIDTH-1:0] instruction_o,
  output logic [WORD_WIDTH-1:0] program_count_o,
  input  logic                  id_ready_i
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  if_state_e             state, state_next;
  logic [WORD_WIDTH-1:0] pc, pc_next;
  logic [WORD_WIDTH-1:0] req_addr;
  logic                  discard, discard_next;
  logic [1:0]            count, count_next;
  logic                  rsp, push, pop, grant, space;
  fetch_entry_t          head;

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (pc_branch_ctrl_i),
    .push_data ('{instr: instr_rdata_i, pc: req_addr}),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IF_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    rsp          = (state == IF_WAIT) && instr_rvalid_i;
    push         = rsp && !discard && !pc_branch_ctrl_i;
    pop          = instr_valid_o && id_ready_i && !pc_branch_ctrl_i;
    grant        = (state == IF_REQ) && instr_gnt_i;
    count_next   = pc_branch_ctrl_i ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    space        = count_next < DEPTH;
    pc_next      = pc;
    discard_next = discard;
    state_next   = state;

    // A request redirected before its grant keeps its address; the PC already
    // holds the target, so the grant must not advance it.
    if (pc_branch_ctrl_i) begin
      pc_next = word_align(pc_branch_addr_i);
    end else if (grant && !discard) begin
      pc_next = pc + 32'd4;
    end

    if (rsp) begin
      discard_next = 1'b0;
    end
    if (pc_branch_ctrl_i && ((state == IF_REQ) || ((state == IF_WAIT) && !instr_rvalid_i))) begin
      discard_next = 1'b1;
    end

    unique case (state)
      IF_IDLE: if (fetch_enable_i && space) state_next = IF_REQ;
      IF_REQ:  if (instr_gnt_i) state_next = IF_WAIT;
      IF_WAIT: if (instr_rvalid_i) state_next = (fetch_enable_i && space) ? IF_REQ : IF_IDLE;
      default: state_next = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= BOOT_ADDR;
      req_addr <= BOOT_ADDR;
      discard  <= 1'b0;
    end else begin
      pc      <= pc_next;
      discard <= discard_next;
      if ((state_next == IF_REQ) && (state != IF_REQ)) begin
        req_addr <= pc_next;
      end
    end
  end

  always_comb begin
    instr_req_o     = (state == IF_REQ);
    instr_addr_o    = req_addr;
    instr_valid_o   = (count != 2'd0);
    instruction_o   = head.instr;
    program_count_o = head.pc;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a memory model answers requests, stimulus
// queues expected {pc, instr} pairs, and a monitor checks each handshake.
module tb_if_stage;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst_n, fetch_enable, pc_branch_ctrl, id_ready;
  logic [31:0] pc_branch_addr;
  logic        instr_req, instr_gnt, instr_rvalid, instr_valid;
  logic [31:0] instr_addr, instr_rdata, instruction, program_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  logic        pend = 1'b0, keep_pend = 1'b0, gnt_hold = 1'b0;
  logic [31:0] paddr, last_gnt_addr;
  int          rv_delay = 0, wait_cnt = 0, gnt_count = 0;

  if_stage #(.BOOT_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_enable_i   (fetch_enable),
    .pc_branch_ctrl_i (pc_branch_ctrl),
    .pc_branch_addr_i (pc_branch_addr),
    .instr_req_o      (instr_req),
    .instr_addr_o     (instr_addr),
    .instr_gnt_i      (instr_gnt),
    .instr_rvalid_i   (instr_rvalid),
    .instr_rdata_i    (instr_rdata),
    .instr_valid_o    (instr_valid),
    .instruction_o    (instruction),
    .program_count_o  (program_count),
    .id_ready_i       (id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    sb.push_back('{pc: a, instr: memword(a)});
  endtask

  // Memory: grant in the request cycle, answer rv_delay+1 cycles later.
  initial begin
    instr_gnt    = 1'b0;
    instr_rvalid = 1'b0;
    instr_rdata  = '0;
    forever begin
      @(negedge clk);
      instr_rvalid = 1'b0;
      if (!rst_n && !keep_pend) pend = 1'b0;
      if (pend) begin
        if (wait_cnt == 0) begin
          instr_rvalid = 1'b1;
          instr_rdata  = memword(paddr);
          pend         = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      instr_gnt = instr_req && !gnt_hold;
      if (instr_gnt) begin
        pend          = 1'b1;
        paddr         = instr_addr;
        wait_cnt      = rv_delay;
        gnt_count++;
        last_gnt_addr = instr_addr;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && instr_valid && id_ready && !pc_branch_ctrl) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected: got pc %h instr %h expected nothing", program_count, instruction);
        end else begin
          e = sb.pop_front();
          check("head_pc", program_count, e.pc);
          check("head_instr", instruction, e.instr);
        end
      end
    end
  end

  task automatic do_reset(input logic en, input logic rdy);
    @(negedge clk);
    rst_n          = 1'b0;
    fetch_enable   = 1'b0;
    pc_branch_ctrl = 1'b0;
    id_ready       = rdy;
    gnt_hold       = 1'b0;
    rv_delay       = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    check("rst_req", 32'(instr_req), 32'd0);
    check("rst_addr", instr_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc", program_count, 32'h0);
    fetch_enable = en;
    rst_n        = 1'b1;
  endtask

  task automatic wait_req(input logic [31:0] a, input bit stop, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (instr_req && instr_addr == a) hit = 1'b1;
    end
    if (stop) fetch_enable = 1'b0;
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL wait_req: got no request expected request at %h", a);
    end
  endtask

  task automatic drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    fetch_enable = 1'b0;
    id_ready     = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic redirect(input logic [31:0] a);
    @(negedge clk);
    pc_branch_ctrl = 1'b1;
    pc_branch_addr = a;
  endtask

  initial begin
    int g0;
    rst_n          = 1'b0;
    fetch_enable   = 1'b0;
    pc_branch_ctrl = 1'b0;
    pc_branch_addr = '0;
    id_ready       = 1'b0;

    // Linear fetch from reset
    do_reset(1'b1, 1'b1);
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    expect_fetch(32'h8);
    @(negedge clk);
    check("first_req", 32'(instr_req), 32'd1);
    check("first_addr", instr_addr, 32'h0);
    drain(40);

    // Backpressure: two entries buffered, then one slot freed
    do_reset(1'b1, 1'b0);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_no_req", 32'(instr_req), 32'd0);
    end
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_head_pc", program_count, 32'h0);
    check("bp_head_instr", instruction, memword(32'h0));
    g0 = gnt_count;
    expect_fetch(32'h0);
    @(negedge clk);
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    repeat (8) @(negedge clk);
    check("bp_one_grant", 32'(gnt_count - g0), 32'd1);
    check("bp_grant_addr", last_gnt_addr, 32'h8);
    expect_fetch(32'h4);
    expect_fetch(32'h8);
    fetch_enable = 1'b0;
    id_ready     = 1'b1;
    drain(20);

    // Redirect while idle with a full buffer; low address bits are dropped
    do_reset(1'b1, 1'b0);
    repeat (12) @(negedge clk);
    check("ri_full", 32'(instr_valid), 32'd1);
    redirect(32'h0000_0103);
    sb.delete();
    expect_fetch(32'h100);
    @(negedge clk);
    pc_branch_ctrl = 1'b0;
    check("ri_valid", 32'(instr_valid), 32'd0);
    check("ri_req", 32'(instr_req), 32'd1);
    check("ri_addr", instr_addr, 32'h100);
    check("ri_pc_zero", program_count, 32'h0);
    fetch_enable = 1'b0;
    id_ready     = 1'b1;
    drain(20);

    // Redirect while a response is outstanding
    do_reset(1'b0, 1'b1);
    rv_delay = 3;
    redirect(32'h10);
    fetch_enable = 1'b1;
    @(negedge clk);
    pc_branch_ctrl = 1'b0;
    check("rw_req", 32'(instr_req), 32'd1);
    check("rw_addr", instr_addr, 32'h10);
    redirect(32'h200);
    sb.delete();
    expect_fetch(32'h200);
    @(negedge clk);
    pc_branch_ctrl = 1'b0;
    check("rw_wait_no_req", 32'(instr_req), 32'd0);
    wait_req(32'h200, 1'b1, 20);
    drain(30);

    // Redirect with an ungranted request
    do_reset(1'b0, 1'b1);
    gnt_hold = 1'b1;
    redirect(32'h20);
    fetch_enable = 1'b1;
    @(negedge clk);
    pc_branch_ctrl = 1'b0;
    check("ru_req", 32'(instr_req), 32'd1);
    check("ru_addr", instr_addr, 32'h20);
    redirect(32'h40);
    sb.delete();
    expect_fetch(32'h40);
    @(negedge clk);
    pc_branch_ctrl = 1'b0;
    check("ru_hold_req", 32'(instr_req), 32'd1);
    check("ru_hold_addr", instr_addr, 32'h20);
    @(negedge clk);
    check("ru_hold_addr2", instr_addr, 32'h20);
    gnt_hold = 1'b0;
    wait_req(32'h40, 1'b1, 20);
    drain(20);

    // PC wrap at the top of the address space
    do_reset(1'b0, 1'b1);
    redirect(32'hFFFF_FFFC);
    fetch_enable = 1'b1;
    expect_fetch(32'hFFFF_FFFC);
    expect_fetch(32'h0);
    @(negedge clk);
    pc_branch_ctrl = 1'b0;
    wait_req(32'h0, 1'b1, 20);
    id_ready = 1'b1;
    drain(20);

    // Asynchronous reset in WAIT with a buffered entry; late rvalid ignored
    rv_delay = 3;
    redirect(32'h300);
    fetch_enable = 1'b1;
    @(negedge clk);
    pc_branch_ctrl = 1'b0;
    wait_req(32'h304, 1'b1, 30);
    @(negedge clk);
    check("ar_pre_valid", 32'(instr_valid), 32'd1);
    check("ar_pre_pc", program_count, 32'h300);
    check("ar_pre_instr", instruction, memword(32'h300));
    #3;
    keep_pend = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("ar_req", 32'(instr_req), 32'd0);
    check("ar_addr", instr_addr, 32'h0);
    check("ar_valid", 32'(instr_valid), 32'd0);
    check("ar_instr", instruction, 32'h0);
    check("ar_pc", program_count, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    id_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("ar_late_valid", 32'(instr_valid), 32'd0);
    check("ar_late_req", 32'(instr_req), 32'd0);
    keep_pend = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the core: the consumer of the execute stage's redirect outputs (`pc_branch_ctrl`, `pc_branch_addr`). It owns the fetch PC and issues word requests on the instruction-memory req/gnt/rvalid interface. It buffers returned words with their PCs in a 2-entry FIFO and presents them to decode under a valid/ready handshake. A redirect flushes the FIFO and discards any response still in flight.

## Interface
Parameters:
- `BOOT_ADDR`, default `32'h0000_0000`: fetch PC after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 2: instruction buffer entries; only 2 is supported.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_enable_i`  in  1  permits new memory requests.
- `pc_branch_ctrl_i`  in  1  redirect strobe from the execute stage.
- `pc_branch_addr_i`  in  WORD_WIDTH  redirect target.
- `instr_req_o`  out  1  memory request.
- `instr_addr_o`  out  WORD_WIDTH  request address; word aligned.
- `instr_gnt_i`  in  1  request accepted.
- `instr_rvalid_i`  in  1  response data valid.
- `instr_rdata_i`  in  WORD_WIDTH  response instruction word.
- `instr_valid_o`  out  1  FIFO head is valid.
- `instruction_o`  out  WORD_WIDTH  FIFO head instruction.
- `program_count_o`  out  WORD_WIDTH  FIFO head PC.
- `id_ready_i`  in  1  decode accepts the head this cycle.

## Operation
- **Reset values**: fetch PC = `BOOT_ADDR`; `instr_req_o` = 0; `instr_addr_o` = `BOOT_ADDR`; FIFO empty; `instr_valid_o` = 0; `instruction_o` = 0; `program_count_o` = 0.
  - `instruction_o` and `program_count_o` are 0 whenever the FIFO is empty.
- **FSM states**: IDLE, REQ, WAIT.
  - IDLE → REQ when `fetch_enable_i` is high and `count + outstanding < FIFO_DEPTH`.
  - REQ: `instr_req_o` = 1 and `instr_addr_o` = fetch PC. Address and request stay stable until `instr_gnt_i`.
  - On grant: go to WAIT and set `fetch PC += 4` (modulo 2^32; `32'hFFFF_FFFC` wraps to 0).
  - WAIT: on `instr_rvalid_i`, push `{rdata, addr}` into the FIFO. Next state is REQ if enable and space allow, otherwise IDLE.
- **Outstanding limit**: at most one granted-but-unreturned request.
- **Consume**: an entry is popped when `instr_valid_o && id_ready_i`. Push and pop in the same cycle keeps the count unchanged.
- **Redirect** (`pc_branch_ctrl_i` = 1); redirect has priority over any push or pop in that cycle:
  - fetch PC ← `{pc_branch_addr_i[31:2], 2'b00}`;
  - the FIFO is flushed at the clock edge;
  - the discard flag is set if a request is in WAIT, or is in REQ without grant.
- **Request pending at redirect**: a request that is in REQ without grant is not withdrawn.
  - When it is granted, it completes and its response is dropped.
  - The next request then uses the new PC.
- **Discard flag**: while set, the next `instr_rvalid_i` is not pushed. The flag clears on that rvalid.
- **Redirect in the same cycle as rvalid**: the response is dropped, not pushed.
- **`fetch_enable_i` low**: no new REQ is entered. A REQ already asserted stays asserted until grant. An outstanding response still completes. The FIFO continues to drain.
- **Illegal input**: `instr_rvalid_i` with nothing outstanding is ignored.

## Timing
- `instr_req_o` can rise in the first cycle after reset deassertion, if `fetch_enable_i` is high.
- Grant is accepted in the same cycle as the request. rvalid arrives no earlier than the cycle after grant.
- rvalid in cycle N → `instr_valid_o` = 1 in cycle N+1 (no bypass).
- Minimum latency from request to `instr_valid_o`: 2 cycles when `gnt` is immediate and `rvalid` follows one cycle later.
- Redirect in cycle N:
  - `instr_valid_o` = 0 in N+1;
  - if idle, `instr_req_o` with the new address in N+1;
  - the earliest valid redirected instruction appears in N+3.
- Steady-state throughput is 1 instruction per 2 cycles, limited by the single outstanding request.
- Asynchronous reset mid-transaction returns all state to reset values immediately. Responses arriving after reset release are ignored, because outstanding = 0.

## Structure
- `riscv_defines` package: add `FETCH_FIFO_DEPTH` (= 2) and `typedef enum logic [1:0] {IF_IDLE, IF_REQ, IF_WAIT} if_state_e`. `WORD_WIDTH` comes from the same package.
- Sub-module `fetch_fifo`:
  - 2 entries of `{instruction, pc}`;
  - push, pop and flush inputs, with flush dominant;
  - outputs: count and head.

## Test plan
- **Reset and linear fetch**: reset release, enable = 1, gnt immediate, rvalid after 1 cycle, `id_ready` = 1 → PCs 0x0, 0x4, 0x8 are presented, with `instruction_o` equal to the memory words.
- **Backpressure**: `id_ready` = 0 → after 2 pushes `instr_req_o` stays 0. Raising `id_ready` for one cycle → exactly one new request at 0x8.
- **Redirect while idle**: `pc_branch_ctrl` = 1 with `pc_branch_addr` = 0x100 and the FIFO full → `instr_valid_o` = 0 the next cycle, the next request address is 0x100, and 0x100 is the first PC presented.
- **Redirect during WAIT**: redirect to 0x200 while the 0x10 response is outstanding → the 0x10 word is never presented, and 0x200 follows.
- **Redirect with ungranted request**: `req` at 0x20 with gnt held low, then redirect to 0x40 → address stays 0x20 until gnt, the 0x20 response is dropped, and the next request is 0x40.
- **Wrap and async reset**: the request at 0xFFFF_FFFC is followed by a request at 0x0. Asserting `rst_n` = 0 mid-WAIT → all outputs return to reset values asynchronously, and a late rvalid is ignored.
